// File: rtl/config_streamer_if.sv
// config_streamer_if
// Groups the host byte stream, the status flags and the shared configId/configData bus of config_streamer.
//   tracing    : system tracing mode; config bytes advance only while low
//   in_valid   : host byte valid
//   in_data    : host byte
//   in_ready   : buffer can take a byte
//   err_clear  : clears the sticky error flag
//   configId   : target block ID, or the idle ID between packets
//   configData : payload byte on the bus
//   busy       : packet engine not idle
//   done       : one-cycle pulse at the end of each packet
//   error      : sticky, a packet was dropped
//
// Handshake: a host byte transfers on a rising clk edge where in_valid and in_ready are both high. in_ready
// depends only on buffer occupancy, never on in_valid. in_data must stay stable while in_valid is high and
// in_ready is low.
interface config_streamer_if;
  logic       tracing;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       err_clear;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;
  logic       error;

  modport slave (
    input  tracing, in_valid, in_data, err_clear,
    output in_ready, configId, configData, busy, done, error
  );

  modport master (
    output tracing, in_valid, in_data, err_clear,
    input  in_ready, configId, configData, busy, done, error
  );
endinterface

// File: rtl/config_streamer.sv
// config_streamer
// Firmware configuration transmitter. Host bytes arrive framed as {target id, length, payload...}. They are
// buffered in a byte FIFO. Each legal payload is then replayed on the shared configId/configData bus, one
// byte per non-tracing cycle. Between packets configId rests at IDLE_ID, so every receiver rewinds its byte
// counter.
// Ports:
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   bus         : config_streamer_if.slave (host stream, config bus, status)
//   o_dbg_state : current FSM state; 0 means idle
module config_streamer #(
  parameter int         FIFO_DEPTH = 256,
  parameter logic [7:0] IDLE_ID    = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  config_streamer_if.slave  bus,
  output logic [2:0]        o_dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_LEN = 3'd1,
    ST_WAIT    = 3'd2,
    ST_STREAM  = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Packet engine
  state_t     r_state,    w_state_nxt;
  logic [7:0] r_tgt,      w_tgt_nxt;
  logic [7:0] r_len,      w_len_nxt;
  logic [8:0] r_rem,      w_rem_nxt;
  logic [7:0] r_cfg_id,   w_cfg_id_nxt;
  logic [7:0] r_cfg_data, w_cfg_data_nxt;
  logic       r_done,     w_done_nxt;
  logic       r_busy;
  logic       r_error;
  logic       w_set_err;

  logic       w_in_ready;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic [7:0] w_head;
  logic       w_enough;
  logic       w_too_long;

  assign w_in_ready = (r_count < DEPTH_C);
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_mem[r_rd_ptr];
  // The whole payload must be buffered before the first byte goes out.
  // After that, STREAM can pop every cycle without checking occupancy.
  assign w_enough   = (32'(r_count) >= 32'(r_len));
  assign w_too_long = (32'(w_head) > 32'(FIFO_DEPTH));

  // ---------------- byte FIFO ----------------
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- FSM: next state / outputs ----------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_tgt_nxt      = r_tgt;
    w_len_nxt      = r_len;
    w_rem_nxt      = r_rem;
    w_cfg_id_nxt   = r_cfg_id;
    w_cfg_data_nxt = r_cfg_data;
    w_done_nxt     = 1'b0;
    w_set_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_id_nxt = IDLE_ID;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_tgt_nxt   = w_head;
          w_state_nxt = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_len_nxt = w_head;
          w_rem_nxt = {1'b0, w_head};
          if (w_head == 8'd0) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if ((r_tgt == IDLE_ID) || w_too_long) begin
            w_set_err   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_enough) begin
          w_pop          = 1'b1;
          w_cfg_data_nxt = w_head;
          w_cfg_id_nxt   = r_tgt;
          w_rem_nxt      = r_rem - 9'd1;
          w_state_nxt    = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // While tracing, receivers ignore the bus, so the current byte is held and not counted as consumed.
        if (!bus.tracing) begin
          if (r_rem != 9'd0) begin
            w_pop          = 1'b1;
            w_cfg_data_nxt = w_head;
            w_rem_nxt      = r_rem - 9'd1;
          end else begin
            w_cfg_id_nxt   = IDLE_ID;
            w_cfg_data_nxt = 8'd0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (r_rem == 9'd0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!w_empty) begin
          w_pop     = 1'b1;
          w_rem_nxt = r_rem - 9'd1;
        end
      end
      default: begin
        w_cfg_id_nxt = IDLE_ID;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // ---------------- FSM: registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tgt      <= 8'd0;
      r_len      <= 8'd0;
      r_rem      <= 9'd0;
      r_cfg_id   <= IDLE_ID;
      r_cfg_data <= 8'd0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_len      <= w_len_nxt;
      r_rem      <= w_rem_nxt;
      r_cfg_id   <= w_cfg_id_nxt;
      r_cfg_data <= w_cfg_data_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      // A new drop takes priority over a clear in the same cycle.
      r_error    <= w_set_err | (r_error & ~bus.err_clear);
    end
  end

  // All pops are gated on occupancy, so an empty pop means the engine is broken.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(w_pop && w_empty));
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.configId   = r_cfg_id;
  assign bus.configData = r_cfg_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_config_streamer.sv
`timescale 1ns/1ps
module tb_config_streamer;
  localparam int         DEPTH = 256;
  localparam logic [7:0] IDLE  = 8'hFF;

  // ---------------- clock / reset ----------------
  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic [2:0] dbg_state;

  config_streamer_if cs_if();

  config_streamer #(.FIFO_DEPTH(DEPTH), .IDLE_ID(IDLE)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (cs_if.slave),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: packet parser ----------------
  logic [15:0] exp_q[$];     // {id, data} in the order receivers must consume them
  int          exp_done = 0;
  int          act_done = 0;
  logic        exp_err  = 1'b0;
  int          p_phase  = 0; // 0: expecting tgt, 1: expecting len, 2: payload
  logic [7:0]  p_tgt;
  int          p_left;
  bit          p_legal;

  task automatic model_push(input logic [7:0] b);
    case (p_phase)
      0: begin
        p_tgt   = b;
        p_phase = 1;
      end
      1: begin
        p_left  = int'(b);
        p_legal = (p_tgt != IDLE) && (p_left <= DEPTH);
        if (p_left == 0) begin
          exp_done++;
          p_phase = 0;
        end else begin
          if (!p_legal) exp_err = 1'b1;
          p_phase = 2;
        end
      end
      default: begin
        if (p_legal) exp_q.push_back({p_tgt, b});
        p_left--;
        if (p_left == 0) begin
          exp_done++;
          p_phase = 0;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  int n_acc         = 0;
  int first_wait_at = -1;

  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    cs_if.in_valid = 1'b1;
    cs_if.in_data  = b;
    @(negedge clk);
    while (!cs_if.in_ready && guard < 3000) begin
      if (first_wait_at < 0) first_wait_at = n_acc;
      @(negedge clk);
      guard++;
    end
    if (cs_if.in_ready) begin
      @(posedge clk); #1;
      n_acc++;
      model_push(b);
    end else begin
      chk("push_accept", cs_if.in_ready, 1);
      @(posedge clk); #1;
    end
    cs_if.in_valid = 1'b0;
  endtask

  task automatic push_list(input logic [7:0] q[$]);
    foreach (q[k]) push_byte(q[k]);
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int n = 0;
    while (n < budget &&
           !(exp_q.size() == 0 && p_phase == 0 && act_done == exp_done && !cs_if.busy)) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_quiet_in_time"}, (n < budget), 1);
    chk({tag, "_done_count"}, act_done, exp_done);
    chk({tag, "_all_bytes_seen"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  logic [7:0] tr_id[$];
  logic [7:0] tr_data[$];
  logic       tr_done[$];
  int         ff_run    = 0;
  bit         seen_pkt  = 0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_id   = IDLE;
  logic [15:0] mon_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      ff_run    = 0;
      seen_pkt  = 0;
      prev_done = 1'b0;
      prev_id   = IDLE;
    end else begin
      tr_id.push_back(cs_if.configId);
      tr_data.push_back(cs_if.configData);
      tr_done.push_back(cs_if.done);
      if (cs_if.done) act_done++;
      if (prev_done) chk("done_single_cycle", cs_if.done, 0);
      if (cs_if.configId == IDLE) begin
        ff_run++;
      end else begin
        chk("busy_while_on_bus", cs_if.busy, 1);
        if (prev_id == IDLE) begin
          if (seen_pkt) chk("idle_gap_at_least_3", (ff_run >= 3), 1);
          seen_pkt = 1;
        end else begin
          chk("id_stable_in_packet", cs_if.configId, prev_id);
        end
        ff_run = 0;
        // Receivers take the byte at the coming edge only when tracing is low.
        if (!cs_if.tracing) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bus_byte", {cs_if.configId, cs_if.configData}, 32'hFFFF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("bus_byte", {cs_if.configId, cs_if.configData}, mon_exp);
          end
        end
      end
      prev_id   = cs_if.configId;
      prev_done = cs_if.done;
    end
  end

  // ---------------- trace helpers ----------------
  task automatic tr_clear();
    tr_id.delete();
    tr_data.delete();
    tr_done.delete();
  endtask

  function automatic int find_id(input logic [7:0] id);
    foreach (tr_id[k]) if (tr_id[k] == id) return k;
    return -1;
  endfunction

  function automatic int count_id(input logic [7:0] id);
    int c = 0;
    foreach (tr_id[k]) if (tr_id[k] == id) c++;
    return c;
  endfunction

  function automatic int count_id_data(input logic [7:0] id, input logic [7:0] d);
    int c = 0;
    foreach (tr_id[k]) if (tr_id[k] == id && tr_data[k] == d) c++;
    return c;
  endfunction

  function automatic int count_starts(input logic [7:0] id);
    int c = 0;
    foreach (tr_id[k]) if (tr_id[k] == id && (k == 0 || tr_id[k-1] != id)) c++;
    return c;
  endfunction

  function automatic int count_done();
    int c = 0;
    foreach (tr_done[k]) if (tr_done[k]) c++;
    return c;
  endfunction

  // ---------------- directed + random sequence ----------------
  bit rand_run = 0;

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] exp_b[4];
    int i;
    int len;
    logic [7:0] tgt;

    cs_if.tracing   = 1'b0;
    cs_if.in_valid  = 1'b0;
    cs_if.in_data   = 8'h00;
    cs_if.err_clear = 1'b0;

    // Reset values, observed while reset is still held.
    #1 reset_n = 1'b0;
    #1;
    chk("reset_configId",   cs_if.configId,   IDLE);
    chk("reset_configData", cs_if.configData, 0);
    chk("reset_busy",       cs_if.busy,       0);
    chk("reset_done",       cs_if.done,       0);
    chk("reset_error",      cs_if.error,      0);
    chk("reset_in_ready",   cs_if.in_ready,   1);
    chk("reset_state_idle", dbg_state,        0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // ---- T1: basic packet; the second copy is fully buffered, giving the exact 3-cycle gap ----
    tr_clear();
    pkt = '{8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_list(pkt);
    wait_quiet(2000, "t1");
    i = find_id(8'h05);
    chk("t1_window", (i >= 0 && i + 8 <= tr_id.size()), 1);
    if (i >= 0 && i + 8 <= tr_id.size()) begin
      for (int k = 0; k < 4; k++) begin
        chk("t1_id",   tr_id[i+k],   8'h05);
        chk("t1_data", tr_data[i+k], exp_b[k]);
      end
      chk("t1_end_id",        tr_id[i+4],   IDLE);
      chk("t1_end_data",      tr_data[i+4], 0);
      chk("t1_done_pulse",    tr_done[i+4], 1);
      chk("t1_done_off",      tr_done[i+5], 0);
      chk("t1_gap_id",        tr_id[i+6],   IDLE);
      chk("t1_second_start",  {tr_id[i+7], tr_data[i+7]}, 16'h0511);
    end
    chk("t1_error", cs_if.error, exp_err);

    // ---- T2: tracing held high for 3 edges while 22 is on the bus ----
    tr_clear();
    pkt = '{8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    fork
      push_list(pkt);
      begin : t2_tracing
        int n;
        n = 0;
        while (n < 200 && !(cs_if.configId == 8'h05 && cs_if.configData == 8'h22)) begin
          @(posedge clk); #1;
          n++;
        end
        chk("t2_saw_22", (n < 200), 1);
        cs_if.tracing = 1'b1;
        repeat (3) @(posedge clk);
        #1 cs_if.tracing = 1'b0;
      end
    join
    wait_quiet(2000, "t2");
    chk("t2_packet_cycles", count_id(8'h05), 7);
    chk("t2_22_cycles",     count_id_data(8'h05, 8'h22), 4);
    chk("t2_done_pulses",   count_done(), 1);

    // ---- T3: two back-to-back packets to the same ID ----
    tr_clear();
    pkt = '{8'h03, 8'h02, 8'hAA, 8'hBB, 8'h03, 8'h01, 8'hCC};
    push_list(pkt);
    wait_quiet(2000, "t3");
    chk("t3_packet_starts", count_starts(8'h03), 2);
    chk("t3_done_pulses",   count_done(), 2);
    chk("t3_error",         cs_if.error, exp_err);

    // ---- T4: packet to the reserved ID is dropped, the next one is delivered ----
    tr_clear();
    pkt = '{8'hFF, 8'h02, 8'h01, 8'h02, 8'h07, 8'h01, 8'h5A};
    push_list(pkt);
    wait_quiet(2000, "t4");
    chk("t4_error_set",     cs_if.error, exp_err);
    chk("t4_id07_cycles",   count_id(8'h07), 1);
    chk("t4_done_pulses",   count_done(), 2);
    cs_if.err_clear = 1'b1;
    @(posedge clk); #1;
    cs_if.err_clear = 1'b0;
    exp_err = 1'b0;
    chk("t4_error_cleared", cs_if.error, exp_err);

    // ---- T5: zero-length packet, then a stalled 255-byte packet fills the FIFO ----
    tr_clear();
    cs_if.tracing = 1'b1;
    pkt = '{8'h09, 8'h00, 8'h0A, 8'hFF};
    for (int k = 0; k < 255; k++) pkt.push_back(8'($urandom_range(0, 255)));
    pkt.push_back(8'h0B);
    pkt.push_back(8'h01);
    pkt.push_back(8'h77);
    n_acc = 0;
    first_wait_at = -1;
    fork
      push_list(pkt);
      begin : t5_watch
        int n;
        n = 0;
        while (n < 2000 && n_acc < 261) begin
          @(negedge clk);
          n++;
        end
        chk("t5_bytes_before_full", n_acc, 261);
        repeat (4) begin
          @(negedge clk);
          chk("t5_in_ready_low_when_full", cs_if.in_ready, 0);
        end
        chk("t5_nothing_taken_while_full", n_acc, 261);
        @(posedge clk); #1;
        cs_if.tracing = 1'b0;
      end
    join
    wait_quiet(3000, "t5");
    chk("t5_first_refusal_at", first_wait_at, 261);
    chk("t5_done_pulses",      count_done(), 3);
    chk("t5_id0A_starts",      count_starts(8'h0A), 1);

    // ---- T6: asynchronous reset in the middle of a stream ----
    pkt = '{8'h0C, 8'h10};
    for (int k = 0; k < 16; k++) pkt.push_back(8'($urandom_range(0, 255)));
    push_list(pkt);
    i = 0;
    while (i < 200 && cs_if.configId != 8'h0C) begin
      @(posedge clk); #1;
      i++;
    end
    chk("t6_stream_started", cs_if.configId, 8'h0C);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_configId", cs_if.configId,   IDLE);
    chk("t6_async_data",     cs_if.configData, 0);
    chk("t6_async_busy",     cs_if.busy,       0);
    chk("t6_async_in_ready", cs_if.in_ready,   1);
    exp_q.delete();
    p_phase  = 0;
    exp_done = act_done;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    tr_clear();
    pkt = '{8'h0D, 8'h03};
    for (int k = 0; k < 3; k++) pkt.push_back(8'($urandom_range(0, 255)));
    push_list(pkt);
    wait_quiet(2000, "t6");
    i = find_id(8'h0D);
    chk("t6_fresh_found", (i >= 0), 1);
    if (i >= 0) chk("t6_fresh_byte0", tr_data[i], pkt[2]);
    chk("t6_fresh_cycles", count_id(8'h0D), 3);

    // ---- Random packets with random tracing ----
    rand_run = 1;
    fork
      begin : rnd_tracing
        while (rand_run) begin
          cs_if.tracing = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
        cs_if.tracing = 1'b0;
      end
      begin : rnd_packets
        for (int p = 0; p < 12; p++) begin
          tgt = ($urandom_range(0, 5) == 0) ? IDLE : 8'($urandom_range(0, 254));
          len = $urandom_range(0, 7);
          pkt = '{tgt, 8'(len)};
          for (int k = 0; k < len; k++) pkt.push_back(8'($urandom_range(0, 255)));
          push_list(pkt);
        end
        wait_quiet(5000, "rand");
        rand_run = 0;
      end
    join
    chk("rand_error", cs_if.error, exp_err);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
